punc_mem_responder: RTL and testbench
=====================================

Name: punc_mem_responder

Overview:
Memory-side responder for the PUnC multicycle core. It serves word read and write requests issued by the core's control/datapath over a valid/ready request channel and a one-cycle response pulse. It sequences indirect accesses (LDI/STI-style) in hardware: first a pointer read, then the data access at the pointer value. It owns a single-port word array of 2^ADDR_W x 16 bits and replaces a combinational memory, so the core can tolerate multi-cycle memory latency.

Parameters:
ADDR_W, 8, array address width; depth = 2^ADDR_W words.
READ_LAT, 2, cycles per array access phase; legal range 1..8.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = write, 0 = read
req_ind  input  1  1 = indirect access (address operand is a pointer location)
req_addr  input  16  word address, or pointer location if req_ind
req_wdata  input  16  write data
rsp_valid  output  1  one-cycle completion pulse; read data or write acknowledge
rsp_rdata  output  16  read data, valid only while rsp_valid is high; 0 for writes
rsp_fault  output  1  address fault flag, valid with rsp_valid (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, latency counter=0. Array contents are not cleared.
- Reset mid-operation aborts the request. No pending write is performed, and no response is produced after reset releases.
- States:
  - IDLE: req_ready=1.
  - PTR: pointer read, indirect requests only.
  - ACC: data access.
  - RESP: rsp_valid=1.
- Accept: req_valid && req_ready at a rising edge. That cycle is cycle 0. Latch we, ind, addr, and wdata.
- Next state after accept: PTR if ind, else ACC. The counter loads READ_LAT-1.
- Each phase lasts exactly READ_LAT cycles; the counter decrements to 0.
- PTR end: the effective address is the pointer word mem[addr[ADDR_W-1:0]] (all 16 bits captured). Next state is ACC with the counter reloaded.
- ACC end:
  - Read: capture mem[eff[ADDR_W-1:0]] into rsp_rdata.
  - Write: mem[eff[ADDR_W-1:0]] <= wdata at the same edge.
  - Next state is RESP.
- Latency: rsp_valid is high in cycle READ_LAT+1 for direct requests and in cycle 2*READ_LAT+1 for indirect requests. It is high for exactly one cycle.
- RESP always goes to IDLE, so req_ready=1 in the following cycle.
- Back-to-back: the earliest next accept is the cycle after RESP.
- req_ready=0 in every non-IDLE state. req_valid while busy is ignored, not queued.
- No response backpressure: the requester must sample rsp_valid when it pulses.
- Address wrap (feature off): bits [15:ADDR_W] of the address and of the pointer are ignored, so addresses alias modulo depth.
- Indirect write: only the target word is written; the pointer word is never modified.
- rsp_rdata holds its last value outside rsp_valid; the consumer must not rely on it.

Optional Feature:
Macro PUNC_MEM_FAULT_EN.
- Defined:
  - A request faults when req_addr[15:ADDR_W]!=0, or for indirect requests when pointer[15:ADDR_W]!=0.
  - A faulting request still completes with normal latency. A faulting request address skips the pointer read but keeps the indirect timing.
  - The response has rsp_fault=1 and rsp_rdata=0, and no array write occurs.
- Undefined: rsp_fault is tied to 0 and the wrap behaviour applies.

Test Plan:
1. READ_LAT=2: write req_addr=0x0010, wdata=0xBEEF -> rsp_valid only in cycle 3, rsp_fault=0. Then read 0x0010 -> rsp_valid in cycle 3 with rsp_rdata=0xBEEF.
2. Preload mem[0x20]=0x0030, mem[0x30]=0x1234; indirect read at 0x20 -> rsp_valid in cycle 5 with rsp_rdata=0x1234; req_ready=0 in cycles 1..5.
3. Preload mem[0x21]=0x0040; indirect write at 0x21 with wdata=0x5A5A -> mem[0x40]=0x5A5A and mem[0x21] still 0x0040.
4. Hold req_valid high with addr changing every cycle -> only the cycle-0 request is served. The next accept occurs in cycle 4 (READ_LAT=2), and exactly one rsp_valid pulse is seen per accepted request.
5. Assert rst_n low in cycle 2 of an indirect write to 0x21 -> rsp_valid=0 and req_ready=1 immediately. The target word is unchanged and no response follows release.
6. ADDR_W=8, write 0x0100 with data 0x7777:
   - Macro on: rsp_fault=1, mem[0x00] unchanged.
   - Macro off: mem[0x00]=0x7777, rsp_fault=0.

Source files
------------

// File: rtl/punc_mem_responder_if.sv
// rtl/punc_mem_responder_if.sv - request/response bus between the PUnC core and its memory responder
interface punc_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_ind;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_ind, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_ind, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/punc_mem_responder.sv
// rtl/punc_mem_responder.sv - multicycle word memory responder with hardware indirect (pointer) sequencing
// Optional out-of-range address faulting is enabled by defining PUNC_MEM_FAULT_EN.
module punc_mem_responder #(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    punc_mem_responder_if.slave  bus
);
    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        ACC  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] eff_q, eff_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic [15:0] mem [DEPTH];
    logic [15:0] mem_rd;
    logic        mem_we;
    logic        req_ready;
    logic        rsp_valid;

    // Both phases address the array through eff: the pointer location in PTR, the target in ACC.
    assign mem_rd = mem[eff_q[ADDR_W-1:0]];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        eff_d     = eff_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        mem_we    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    eff_d   = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = LAT_M1;
                    state_d = bus.req_ind ? PTR : ACC;
`ifdef PUNC_MEM_FAULT_EN
                    fault_d = |(bus.req_addr >> ADDR_W);
`else
                    fault_d = 1'b0;
`endif
                end
            end
            PTR: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = ACC;
                    // A faulted pointer location is never dereferenced; the phase still runs its full length.
                    if (!fault_q) begin
                        eff_d = mem_rd;
`ifdef PUNC_MEM_FAULT_EN
                        fault_d = |(mem_rd >> ADDR_W);
`endif
                    end
                end
            end
            ACC: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = RESP;
                    if (fault_q || we_q) begin
                        rdata_d = 16'h0000;
                        mem_we  = we_q && !fault_q;
                    end else begin
                        rdata_d = mem_rd;
                    end
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            eff_q   <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            eff_q   <= eff_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Array has no reset; a reset forces IDLE asynchronously, so mem_we is already low at the next edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[eff_q[ADDR_W-1:0]] <= wdata_q;
        end
    end

    logic unused_hi;
    assign unused_hi = |(eff_q >> ADDR_W);

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_fault = fault_q && rsp_valid;
endmodule

// File: tb/tb_punc_mem_responder.sv
// tb/tb_punc_mem_responder.sv - self-checking bench for punc_mem_responder (vector table, corner sequences, random vs model)
module tb_punc_mem_responder;
    localparam int AW    = 8;
    localparam int RL    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int LAT_D = RL + 1;
    localparam int LAT_I = 2 * RL + 1;
    localparam int TMO   = 4 * RL + 8;
`ifdef PUNC_MEM_FAULT_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    punc_mem_responder_if bus();
    punc_mem_responder #(.ADDR_W(AW), .READ_LAT(RL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] ref_mem [DEPTH];

    typedef struct {
        string       name;
        bit          we;
        bit          ind;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        bit          exp_fault;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is positioned at a negedge with the responder idle; returns at the negedge after the response.
    task automatic issue(input string name, input bit we, input bit ind, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rdata, input bit exp_fault);
        int exp_lat;
        bit seen;
        exp_lat = ind ? LAT_I : LAT_D;
        seen = 1'b0;
        chk({name, "_ready_c0"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_ind   = ind;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int cyc = 1; cyc <= TMO; cyc++) begin
            chk({name, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                chk({name, "_latency"}, 32'(cyc), 32'(exp_lat));
                chk({name, "_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
                chk({name, "_fault"}, 32'(bus.rsp_fault), 32'(exp_fault));
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({name, "_rsp_single"}, 32'(bus.rsp_valid), 32'd0);
        chk({name, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    endtask

    // Reference: addresses alias modulo depth unless faulting is on, then any high bit faults.
    task automatic ref_issue(input bit we, input bit ind, input logic [15:0] addr, input logic [15:0] wdata);
        logic [15:0] eff;
        logic [15:0] rd;
        bit f;
        f   = FE && (int'(addr) >= DEPTH);
        eff = addr;
        if (ind && !f) begin
            eff = ref_mem[int'(addr) % DEPTH];
            f   = FE && (int'(eff) >= DEPTH);
        end
        rd = 16'h0000;
        if (!f) begin
            if (we) ref_mem[int'(eff) % DEPTH] = wdata;
            else    rd = ref_mem[int'(eff) % DEPTH];
        end
        issue("rnd", we, ind, addr, wdata, rd, f);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_ind   = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 16'h0000;

        vecs.push_back('{"wr_10",      1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0});
        vecs.push_back('{"rd_10",      1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0});
        vecs.push_back('{"wr_20",      1'b1, 1'b0, 16'h0020, 16'h0030, 16'h0000, 1'b0});
        vecs.push_back('{"wr_30",      1'b1, 1'b0, 16'h0030, 16'h1234, 16'h0000, 1'b0});
        vecs.push_back('{"ind_rd_20",  1'b0, 1'b1, 16'h0020, 16'h0000, 16'h1234, 1'b0});
        vecs.push_back('{"wr_21",      1'b1, 1'b0, 16'h0021, 16'h0040, 16'h0000, 1'b0});
        vecs.push_back('{"ind_wr_21",  1'b1, 1'b1, 16'h0021, 16'h5A5A, 16'h0000, 1'b0});
        vecs.push_back('{"rd_40",      1'b0, 1'b0, 16'h0040, 16'h0000, 16'h5A5A, 1'b0});
        vecs.push_back('{"rd_21_ptr",  1'b0, 1'b0, 16'h0021, 16'h0000, 16'h0040, 1'b0});
        vecs.push_back('{"wr_00",      1'b1, 1'b0, 16'h0000, 16'h1111, 16'h0000, 1'b0});
        vecs.push_back('{"wr_100",     1'b1, 1'b0, 16'h0100, 16'h7777, 16'h0000, FE});
        vecs.push_back('{"rd_00",      1'b0, 1'b0, 16'h0000, 16'h0000, FE ? 16'h1111 : 16'h7777, 1'b0});
        vecs.push_back('{"rd_110",     1'b0, 1'b0, 16'h0110, 16'h0000, FE ? 16'h0000 : 16'hBEEF, FE});
        vecs.push_back('{"wr_50",      1'b1, 1'b0, 16'h0050, 16'h0A0A, 16'h0000, 1'b0});
        vecs.push_back('{"wr_22",      1'b1, 1'b0, 16'h0022, 16'h0150, 16'h0000, 1'b0});
        vecs.push_back('{"ind_rd_22",  1'b0, 1'b1, 16'h0022, 16'h0000, FE ? 16'h0000 : 16'h0A0A, FE});
        vecs.push_back('{"ind_wr_120", 1'b1, 1'b1, 16'h0120, 16'hDEAD, 16'h0000, FE});
        vecs.push_back('{"rd_30",      1'b0, 1'b0, 16'h0030, 16'h0000, FE ? 16'h1234 : 16'hDEAD, 1'b0});

        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("reset_fault", 32'(bus.rsp_fault), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].name, vecs[i].we, vecs[i].ind, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_rdata, vecs[i].exp_fault);
        end

        // Held request with a changing operand: only cycles 0 and 4 may be accepted.
        for (int c = 0; c < 9; c++) begin
            bus.req_valid = (c < 5);
            bus.req_ind   = 1'b0;
            bus.req_we    = (c != 0 && c != 4);
            bus.req_addr  = (c == 0) ? 16'h0010 : (c == 4) ? 16'h0020 : 16'($urandom_range(0, 255));
            bus.req_wdata = 16'($urandom);
            chk("held_ready", 32'(bus.req_ready), 32'(c == 0 || c == 4 || c == 8));
            chk("held_rsp_valid", 32'(bus.rsp_valid), 32'(c == 3 || c == 7));
            if (c == 3) chk("held_rdata_1", 32'(bus.rsp_rdata), 32'h0000BEEF);
            if (c == 7) chk("held_rdata_2", 32'(bus.rsp_rdata), 32'h00000030);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        issue("held_noclobber_20", 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0030, 1'b0);

        // Reset in cycle 2 of an indirect write must abort it without a response.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_ind   = 1'b1;
        bus.req_addr  = 16'h0021;
        bus.req_wdata = 16'h9999;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        issue("abort_target", 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h5A5A, 1'b0);
        issue("abort_ptr", 1'b0, 1'b0, 16'h0021, 16'h0000, 16'h0040, 1'b0);

        for (int i = 0; i < DEPTH; i++) ref_issue(1'b1, 1'b0, 16'(i), 16'($urandom));
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a = a | (16'($urandom_range(1, 255)) << 8);
            ref_issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
